// File: rtl/iomem_gpio.sv
// iomem_gpio: memory-mapped GPIO block for the SoC iomem bus.
//   Registers (word offset = iomem_addr[5:2]):
//     0 OUT rw, 1 OE rw, 2 IN ro, 3 SET wo, 4 CLR wo, 5 TGL wo,
//     6 RISE_EN rw, 7 FALL_EN rw, 8 PEND rw1c; 9..15 read 0, ignore writes.
//   Ports:
//     clk, resetn          - clock, synchronous active-low reset
//     iomem_valid/ready    - single-cycle-latency handshake, ready pulses once
//     iomem_wstrb/addr/wdata/rdata - bus write strobes, address, data
//     gpio_in              - asynchronous pin inputs (synchronised here)
//     gpio_out, gpio_oe    - output data and per-pin output enable
//     irq                  - registered OR of PEND
module iomem_gpio #(
  parameter int         N_PINS      = 8,
  parameter logic [7:0] BASE_ADDR   = 8'h03,
  parameter int         SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              iomem_valid,
  output logic              iomem_ready,
  input  logic [3:0]        iomem_wstrb,
  input  logic [31:0]       iomem_addr,
  input  logic [31:0]       iomem_wdata,
  output logic [31:0]       iomem_rdata,
  input  logic [N_PINS-1:0] gpio_in,
  output logic [N_PINS-1:0] gpio_out,
  output logic [N_PINS-1:0] gpio_oe,
  output logic              irq
);

  typedef logic [N_PINS-1:0] pins_t;

  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  pins_t      out_q, oe_q, rise_en_q, fall_en_q, pend_q, dly_q;
  pins_t      sync_q [SYNC_STAGES];
  pins_t      sync_s, m, d, ev, pend_nxt;
  logic [2:0] warm_q;
  logic       sel, wr, warm_ok;
  logic [3:0] off;
  logic [31:0] bmask, rd_mux;
  logic       unused_ok;

  assign sel     = iomem_valid && !iomem_ready && (iomem_addr[31:24] == BASE_ADDR);
  assign wr      = sel && (|iomem_wstrb);
  assign off     = iomem_addr[5:2];
  assign bmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                    {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign m       = bmask[N_PINS-1:0];
  assign d       = iomem_wdata[N_PINS-1:0] & m;
  assign sync_s  = sync_q[SYNC_STAGES-1];
  assign warm_ok = (warm_q == WARM_DONE);

  // Bits of the bus beyond the implemented pins are intentionally ignored.
  assign unused_ok = ^{iomem_addr[23:6], iomem_addr[1:0], iomem_wdata, bmask};

  // Edge events are masked until the synchroniser and delay register hold
  // real pin levels, otherwise a pin held high through reset looks like a rise.
  assign ev = warm_ok ? ((sync_s & ~dly_q & rise_en_q) | (~sync_s & dly_q & fall_en_q))
                      : '0;

  // Set wins over W1C: the event is OR-ed in after the clear.
  assign pend_nxt = (pend_q & ~((wr && off == 4'd8) ? d : pins_t'(0))) | ev;

  always_comb begin
    rd_mux = '0;
    case (off)
      4'd0: rd_mux[N_PINS-1:0] = out_q;
      4'd1: rd_mux[N_PINS-1:0] = oe_q;
      4'd2: rd_mux[N_PINS-1:0] = sync_s;
      4'd6: rd_mux[N_PINS-1:0] = rise_en_q;
      4'd7: rd_mux[N_PINS-1:0] = fall_en_q;
      4'd8: rd_mux[N_PINS-1:0] = pend_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      out_q       <= '0;
      oe_q        <= '0;
      rise_en_q   <= '0;
      fall_en_q   <= '0;
      pend_q      <= '0;
      dly_q       <= '0;
      warm_q      <= '0;
      irq         <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      iomem_ready <= sel;
      // rdata reflects register state before this access's write lands.
      iomem_rdata <= sel ? rd_mux : '0;
      sync_q[0]   <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      dly_q       <= sync_s;
      if (!warm_ok) warm_q <= warm_q + 3'd1;
      pend_q      <= pend_nxt;
      irq         <= |pend_q;
      if (wr) begin
        case (off)
          4'd0: out_q     <= (out_q & ~m) | d;
          4'd1: oe_q      <= (oe_q & ~m) | d;
          4'd3: out_q     <= out_q | d;
          4'd4: out_q     <= out_q & ~d;
          4'd5: out_q     <= out_q ^ d;
          4'd6: rise_en_q <= (rise_en_q & ~m) | d;
          4'd7: fall_en_q <= (fall_en_q & ~m) | d;
          default: ;
        endcase
      end
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = oe_q;

endmodule

// File: tb/tb_iomem_gpio.sv
module tb_iomem_gpio;

  logic        clk = 0;
  logic        resetn;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr, wdata;
  logic        ready0, ready1, irq0, irq1;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  gin0, gout0, goe0;
  logic [4:0]  gin1, gout1, goe1;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  iomem_gpio #(.N_PINS(8), .BASE_ADDR(8'h03), .SYNC_STAGES(2)) u0 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready0),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata0),
    .gpio_in(gin0), .gpio_out(gout0), .gpio_oe(goe0), .irq(irq0));

  iomem_gpio #(.N_PINS(5), .BASE_ADDR(8'h04), .SYNC_STAGES(2)) u1 (
    .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_ready(ready1),
    .iomem_wstrb(wstrb), .iomem_addr(addr), .iomem_wdata(wdata), .iomem_rdata(rdata1),
    .gpio_in(gin1), .gpio_out(gout1), .gpio_oe(goe1), .irq(irq1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_gpio_out"}, 32'(gout0), 32'h0);
    chk({tag, "_gpio_oe"},  32'(goe0),  32'h0);
    chk({tag, "_irq"},      32'(irq0),  32'h0);
    chk({tag, "_ready"},    32'(ready0), 32'h0);
    chk({tag, "_rdata"},    rdata0,     32'h0);
  endtask

  // One bus access; returns rdata of the ready cycle. Latency is checked
  // against 0 (ready the cycle after the request) or "never" when not expected.
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] dat,
                        input bit exp_rdy, output logic [31:0] r);
    int lat;
    bit hi;
    hi = (a[31:24] == 8'h04);
    @(negedge clk);
    chk("ready_idle", 32'(ready0 | ready1), 32'h0);
    valid = 1; addr = a; wstrb = s; wdata = dat;
    lat = -1; r = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if ((hi ? ready1 : ready0) === 1'b1) begin
        lat = i;
        r = hi ? rdata1 : rdata0;
        break;
      end
    end
    valid = 0; wstrb = '0;
    chk("ready_latency", 32'(lat), exp_rdy ? 32'h0 : 32'hFFFF_FFFF);
  endtask

  task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] dat);
    logic [31:0] r;
    access(a, s, dat, 1'b1, r);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    exp_q.push_back(exp);
    access(a, 4'h0, 32'h0, 1'b1, r);
    chk(tag, r, exp_q.pop_front());
  endtask

  localparam logic [31:0] A_OUT = 32'h0300_0000, A_OE = 32'h0300_0004,
                          A_IN  = 32'h0300_0008, A_SET = 32'h0300_000C,
                          A_CLR = 32'h0300_0010, A_TGL = 32'h0300_0014,
                          A_REN = 32'h0300_0018, A_PEND = 32'h0300_0020;

  initial begin
    logic [31:0] r;
    bit seen;
    resetn = 0; valid = 0; wstrb = 0; addr = 0; wdata = 0;
    gin0 = 8'h08; gin1 = 5'h0;

    // Access attempted while reset is low must never complete.
    @(negedge clk);
    valid = 1; addr = A_OUT; wstrb = 4'hF; wdata = 32'hFF;
    repeat (3) @(negedge clk);
    chk_outs("in_reset");
    valid = 0; wstrb = 0;
    @(negedge clk);
    resetn = 1;
    @(negedge clk);
    chk_outs("after_release");

    // Pin 3 was high through reset: no spurious rise once enabled.
    wr(A_REN, 4'hF, 32'h08);
    repeat (4) @(negedge clk);
    rd(A_PEND, 32'h0, "pend_static");
    chk("irq_static", 32'(irq0), 32'h0);
    rd(A_IN, 32'h08, "in_read");
    wr(A_IN, 4'hF, 32'hFF);
    rd(A_IN, 32'h08, "in_write_ignored");

    // Basic OUT write/read.
    wr(A_OUT, 4'hF, 32'hA5);
    chk("gpio_out_a5", 32'(gout0), 32'hA5);
    rd(A_OUT, 32'hA5, "out_a5");

    // Write returns pre-update value; then SET/CLR/TGL.
    access(A_OUT, 4'hF, 32'hF0, 1'b1, r);
    chk("wr_rdata_old", r, 32'hA5);
    wr(A_SET, 4'hF, 32'h0F); chk("set", 32'(gout0), 32'hFF);
    wr(A_CLR, 4'hF, 32'h30); chk("clr", 32'(gout0), 32'hCF);
    wr(A_TGL, 4'hF, 32'h81); chk("tgl", 32'(gout0), 32'h4E);
    rd(A_SET, 32'h0, "set_reads_0");
    wr(A_OUT, 4'hE, 32'hFFFF_FF00);
    chk("strobe_lane0_off", 32'(gout0), 32'h4E);
    wr(A_OE, 4'h1, 32'h3C);
    chk("gpio_oe", 32'(goe0), 32'h3C);

    // Rising edge on pin 3 sets PEND and irq within SYNC_STAGES+3 cycles.
    @(negedge clk); gin0 = 8'h00;
    repeat (4) @(negedge clk);
    gin0 = 8'h08;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (irq0 === 1'b1) begin seen = 1; break; end
    end
    chk("irq_on_rise", 32'(seen), 32'h1);
    rd(A_PEND, 32'h08, "pend_rise");

    // W1C landing on the same edge as a new enabled rise: set wins.
    @(negedge clk); gin0 = 8'h00;
    repeat (4) @(negedge clk);
    gin0 = 8'h08;
    @(negedge clk);
    wr(A_PEND, 4'hF, 32'h08);
    rd(A_PEND, 32'h08, "pend_set_priority");

    // Plain W1C: irq follows PEND one cycle later.
    wr(A_PEND, 4'hF, 32'h08);
    chk("irq_lag", 32'(irq0), 32'h1);
    @(negedge clk);
    chk("irq_cleared", 32'(irq0), 32'h0);
    rd(A_PEND, 32'h0, "pend_cleared");

    // Decode: wrong base never answers, unmapped offset reads 0.
    access(32'h0200_0000, 4'h0, 32'h0, 1'b0, r);
    rd(32'h0300_0030, 32'h0, "offset12");
    rd(A_OUT, 32'h4E, "out_untouched");

    // Narrow instance: upper bits read 0.
    wr(32'h0400_0004, 4'hF, 32'hFFFF_FFFF);
    rd(32'h0400_0004, 32'h1F, "oe_n5");
    chk("gpio_oe_n5", 32'(goe1), 32'h1F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/iomem_gpio.md
IOMEM_GPIO -- requirements
Module: iomem_gpio

Interface
REQ-001 SHALL have parameter N_PINS, default 8: number of GPIO pins, legal range 1..32.
REQ-002 SHALL have parameter BASE_ADDR, default 8'h03: decode value for iomem_addr[31:24].
REQ-003 SHALL have parameter SYNC_STAGES, default 2: input synchroniser depth, legal range 2..3.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have ports iomem_valid (input, 1), iomem_ready (output, 1), iomem_wstrb (input, 4), iomem_addr (input, 32), iomem_wdata (input, 32) and iomem_rdata (output, 32): the SoC iomem bus.
REQ-007 SHALL have port gpio_in, input, N_PINS: asynchronous pin inputs.
REQ-008 SHALL have port gpio_out, output, N_PINS: output data register.
REQ-009 SHALL have port gpio_oe, output, N_PINS: per-pin output enable, 1 = drive.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt request.

Function
REQ-011 SHALL select the block when iomem_valid is high, iomem_ready is low and iomem_addr[31:24] equals BASE_ADDR; the register offset is iomem_addr[5:2].
REQ-012 SHALL assert iomem_ready for exactly one cycle, in the cycle after a selected access, with iomem_rdata registered in that same cycle.
REQ-013 SHALL never assert iomem_ready for unselected accesses; iomem_ready SHALL be low in the cycle after any ready pulse.
REQ-014 SHALL use this register map (offset:name, access):
  0:OUT rw; 1:OE rw; 2:IN ro; 3:SET wo; 4:CLR wo; 5:TGL wo; 6:RISE_EN rw; 7:FALL_EN rw; 8:PEND rw1c.
REQ-015 SHALL apply byte strobes per byte lane on every writable register; a lane whose wstrb bit is 0 is unaffected.
REQ-016 SHALL implement SET/CLR/TGL as OUT |= d, OUT &= ~d and OUT ^= d, where d is wdata masked by the strobes; these registers read as 0.
REQ-017 SHALL ignore writes to IN; an access to offset 9..15 SHALL complete normally, read 0, and write nothing.
REQ-018 SHALL read bits [31:N_PINS] of every register as 0.
REQ-019 SHALL drive IN with the SYNC_STAGES-deep synchronised gpio_in; a pin change SHALL be visible in IN after SYNC_STAGES cycles.
REQ-020 SHALL detect edges by comparing the synchronised value with a one-cycle-delayed copy: rise = s & ~p, fall = ~s & p.
REQ-021 SHALL set PEND[i] when (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]); PEND SHALL be sticky until cleared.
REQ-022 SHALL clear PEND[i] by writing 1 to bit i of PEND; writing 0 SHALL leave the bit unchanged.
REQ-023 SHALL give set priority over clear when an edge event and a W1C hit the same bit in the same cycle.
REQ-024 SHALL drive irq as the registered OR of PEND, one cycle after PEND changes.
REQ-025 SHALL suppress edge detection for SYNC_STAGES+1 cycles after reset release, using a warm-up counter, so static pin levels cause no spurious PEND.
REQ-026 SHALL return, on a read of OUT in the same access as a SET/CLR/TGL, the value before that update.

Reset
REQ-027 SHALL, while resetn is low at a clock edge, clear OUT, OE, RISE_EN, FALL_EN, PEND, the synchroniser, the delay register and the warm-up counter.
REQ-028 SHALL, while in reset, hold gpio_out = 0, gpio_oe = 0, irq = 0, iomem_ready = 0 and iomem_rdata = 0.
REQ-029 SHALL abandon any access in progress when reset is asserted; no ready pulse SHALL follow reset.

Verification
REQ-030 SHALL be covered by: write OUT=0xA5 with wstrb=0xF -> ready high exactly 1 cycle later; gpio_out=0xA5; read OUT returns 0x000000A5.
REQ-031 SHALL be covered by: OUT=0xF0, then SET 0x0F, CLR 0x30, TGL 0x81 -> gpio_out sequence 0xFF, 0xCF, 0x4E; reading SET returns 0.
REQ-032 SHALL be covered by: gpio_in[3] held 1 through reset release with RISE_EN=0x08 -> PEND stays 0; then 1->0->1 toggle -> PEND=0x08 and irq=1 within SYNC_STAGES+3 cycles.
REQ-033 SHALL be covered by: PEND=0x08, W1C 0x08 in the same cycle as a new enabled rise on pin 3 -> PEND remains 0x08; a later W1C with no edge -> PEND=0, irq=0 one cycle after.
REQ-034 SHALL be covered by: access with addr[31:24]=0x02 -> no ready ever; access to offset 12 -> ready, rdata=0; with N_PINS=5, write OE=0xFFFFFFFF -> reads 0x1F.
REQ-035 SHALL be covered by: resetn low in the cycle valid rises -> no ready; all outputs 0 during reset and one cycle after release.
